// File: rtl/sqrt_control.sv
// -----------------------------------------------------------------------------
// sqrt_control
//
// Sequencer that sits directly in front of the iterative square-root datapath.
// It accepts one request at a time from the host and drives the datapath's
// start/stop/xin inputs. The sequence is: a start pulse, NITER iteration
// cycles, a stop pulse that loads the datapath result register, and then a
// done pulse. From the done cycle onward the datapath sqrt output is valid.
//
// Parameters
//   NITER  datapath iteration cycles between start and stop (>= 1)
//   CW     iteration counter width (must hold NITER-1)
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous reset, active low
//   run      in   request a new square root (sampled at the clock edge)
//   abort    in   synchronous abort; takes priority over run in every state
//   xin_in   in   [31:0] host operand, captured when run is accepted
//   xin      out  [31:0] registered operand to the datapath
//   start    out  one-cycle pulse to the datapath
//   stop     out  one-cycle pulse to the datapath (loads the sqrt register)
//   busy     out  high in START, ITER and STOP
//   done     out  one-cycle completion pulse
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sqrt_control #(
  parameter int NITER = 16,
  parameter int CW    = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        abort,
  input  logic [31:0] xin_in,
  output logic [31:0] xin,
  output logic        start,
  output logic        stop,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ITER,
    STOP,
    DONE
  } state_t;

  // START loads NITER-1 so that ITER lasts exactly NITER cycles: it counts
  // down to zero and leaves on the cycle where the counter already reads zero.
  localparam logic [CW-1:0] ITER_LOAD = CW'(NITER - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] counter;
  logic [CW-1:0] counter_next;
  logic          load_xin;
  logic          accept;

  // A request is only taken when abort is low. This applies both in IDLE
  // and in DONE, where it gives back-to-back operation.
  assign accept = run & ~abort;

  // Next-state logic.
  // NOTE: each signal written here gets a default value first, so every path
  // through the case assigns it and no latch is inferred.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    load_xin     = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          load_xin   = 1'b1;
          state_next = START;
        end
      end

      START: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          counter_next = ITER_LOAD;
          state_next   = ITER;
        end
      end

      ITER: begin
        if (abort) begin
          state_next = IDLE;
        end else if (counter != '0) begin
          // The decrement is gated by the zero test, so the counter never wraps.
          counter_next = counter - CW'(1);
        end else begin
          state_next = STOP;
        end
      end

      STOP: begin
        state_next = abort ? IDLE : DONE;
      end

      DONE: begin
        if (accept) begin
          load_xin   = 1'b1;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, counter and operand registers.
  // NOTE: sequential state uses non-blocking assignments. All registers
  // then update together at the edge, whatever order the statements are in.
  // NOTE: xin is reset along with the control state because it drives the
  // datapath directly and has to come out of reset at a known value. It only
  // changes when a request is accepted, which is why it holds its value
  // through an abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      xin     <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (load_xin) begin
        xin <= xin_in;
      end
    end
  end

  // The pulses and busy are plain decodes of the state register.
  assign start = (state == START);
  assign stop  = (state == STOP);
  assign done  = (state == DONE);
  assign busy  = (state == START) || (state == ITER) || (state == STOP);

endmodule

// File: tb/tb_sqrt_control.sv
// -----------------------------------------------------------------------------
// tb_sqrt_control
//
// Self-checking bench for sqrt_control. It builds two instances:
//   dut   NITER=16 (main build)
//   dut1  NITER=1  (shortest legal build)
//
// Cycle numbering: run is sampled at edge 0, and cycle k is the period just
// after edge k-1. The bench samples every output on the falling edge. At the
// falling edge where run is driven, the bench records the edge counter as the
// base b, so cycle k is seen at the falling edge where cyc == b + k.
//
// Each done pulse the main instance should produce goes into a queue when its
// run is driven. A monitor pops one entry for every done it sees and compares
// the cycle of the done and the xin value against that entry.
// -----------------------------------------------------------------------------
module tb_sqrt_control;

  localparam int NITER  = 16;
  localparam int CW     = 5;
  localparam int PERIOD = NITER + 3;   // run-to-done distance; restart period

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        run     = 1'b0;
  logic        abort   = 1'b0;
  logic        run1    = 1'b0;
  logic [31:0] xin_in  = '0;

  logic [31:0] xin;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;

  logic [31:0] xin1;
  logic        start1;
  logic        stop1;
  logic        busy1;
  logic        done1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [31:0] xin;
  } exp_t;

  exp_t sb_q[$];

  sqrt_control #(.NITER(NITER), .CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .abort   (abort),
    .xin_in  (xin_in),
    .xin     (xin),
    .start   (start),
    .stop    (stop),
    .busy    (busy),
    .done    (done)
  );

  sqrt_control #(.NITER(1), .CW(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run1),
    .abort   (1'b0),
    .xin_in  (xin_in),
    .xin     (xin1),
    .start   (start1),
    .stop    (stop1),
    .busy    (busy1),
    .done    (done1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor for done pulses of the main instance.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: got done at cyc=%0d xin=%0d, required no done",
                 cyc, xin);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || xin !== e.xin) begin
          failures++;
          $display("FAIL sb_done: got cyc=%0d xin=%0d, required cyc=%0d xin=%0d",
                   cyc, xin, e.cyc, e.xin);
        end
      end
    end
  end

  // Drives one request into an idle DUT and follows it cycle by cycle.
  // xin_in is scrambled after capture so that a bad recapture shows up on xin.
  task automatic run_one(input logic [31:0] value, input string name);
    int         b;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    b      = cyc;
    run    = 1'b1;
    xin_in = value;
    sb_q.push_back('{b + PERIOD, value});
    for (int k = 1; k <= NITER + 4; k++) begin
      @(negedge clock);
      if (k == 1) begin
        run    = 1'b0;
        xin_in = ~value;
      end
      exp_v = {(k == 1), (k == NITER + 2), (k <= NITER + 2), (k == NITER + 3)};
      got_v = {start, stop, busy, done};
      checks++;
      if (got_v !== exp_v || xin !== value) begin
        failures++;
        $display("FAIL %s cycle %0d: got {start,stop,busy,done}=%b xin=%0d, required %b xin=%0d",
                 name, k, got_v, xin, exp_v, value);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got %0d outstanding done, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({xin, start, stop, busy, done} !== 36'd0 ||
        {xin1, start1, stop1, busy1, done1} !== 36'd0) begin
      failures++;
      $display("FAIL reset_values: got xin=%0d pulses=%b xin1=%0d pulses1=%b, required all zero",
               xin, {start, stop, busy, done}, xin1, {start1, stop1, busy1, done1});
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({start, stop, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: got pulses=%b, required 0000 with run low",
               {start, stop, busy, done});
    end
  endtask

  task automatic test_single();
    run_one(32'd144, "single");
  endtask

  task automatic test_ignored_run();
    int         b;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    b      = cyc;
    run    = 1'b1;
    xin_in = 32'd144;
    sb_q.push_back('{b + PERIOD, 32'd144});
    for (int k = 1; k <= NITER + 5; k++) begin
      @(negedge clock);
      // Drop run after edge 0, then pulse it again with a new operand in cycle 5.
      run    = (k == 5);
      xin_in = (k == 5) ? 32'd7 : 32'd144;
      exp_v = {(k == 1), (k == NITER + 2), (k <= NITER + 2), (k == NITER + 3)};
      got_v = {start, stop, busy, done};
      checks++;
      if (got_v !== exp_v || xin !== 32'd144) begin
        failures++;
        $display("FAIL ignored_run cycle %0d: got pulses=%b xin=%0d, required %b xin=144",
                 k, got_v, xin, exp_v);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL ignored_run_pending: got %0d outstanding done, required 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int          b;
    int          m;
    logic [3:0]  exp_v;
    logic [3:0]  got_v;
    logic [31:0] exp_x;
    b      = cyc;
    run    = 1'b1;
    xin_in = 32'd100;
    sb_q.push_back('{b + PERIOD, 32'd100});
    sb_q.push_back('{b + 2 * PERIOD, 32'd81});
    for (int k = 1; k <= 2 * PERIOD + 1; k++) begin
      @(negedge clock);
      // The operand changes in the first done cycle and is captured at its
      // closing edge. run stays high through the second start and is then
      // dropped, so there is no third operation.
      if (k == PERIOD) xin_in = 32'd81;
      if (k == PERIOD + 2) run = 1'b0;
      if (k <= 2 * PERIOD) begin
        m     = ((k - 1) % PERIOD) + 1;
        exp_v = {(m == 1), (m == NITER + 2), (m <= NITER + 2), (m == PERIOD)};
      end else begin
        exp_v = 4'b0000;
      end
      exp_x = (k <= PERIOD) ? 32'd100 : 32'd81;
      got_v = {start, stop, busy, done};
      checks++;
      if (got_v !== exp_v || xin !== exp_x) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got pulses=%b xin=%0d, required %b xin=%0d",
                 k, got_v, xin, exp_v, exp_x);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_pending: got %0d outstanding done, required 0", sb_q.size());
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp_v;
    logic [3:0] got_v;
    // abort beats run in IDLE: the request is not accepted.
    run    = 1'b1;
    abort  = 1'b1;
    xin_in = 32'd999;
    @(negedge clock);
    run   = 1'b0;
    abort = 1'b0;
    checks++;
    if ({start, busy} !== 2'b00 || xin === 32'd999) begin
      failures++;
      $display("FAIL abort_idle: got start=%b busy=%b xin=%0d, required no start and no capture",
               start, busy, xin);
    end
    // abort during ITER: back in IDLE in cycle 11, and no stop or done after that.
    run    = 1'b1;
    xin_in = 32'd55;
    for (int k = 1; k <= NITER + 6; k++) begin
      @(negedge clock);
      run    = 1'b0;
      xin_in = 32'd3;
      abort  = (k == 10);
      exp_v  = {(k == 1), 1'b0, (k <= 10), 1'b0};
      got_v  = {start, stop, busy, done};
      checks++;
      if (got_v !== exp_v || xin !== 32'd55) begin
        failures++;
        $display("FAIL abort_iter cycle %0d: got pulses=%b xin=%0d, required %b xin=55",
                 k, got_v, xin, exp_v);
      end
    end
    run_one(32'd9, "after_abort");
  endtask

  task automatic test_reset_mid();
    run    = 1'b1;
    xin_in = 32'd77;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      run = 1'b0;
    end
    // Assert reset in the middle of cycle 8, away from both clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({xin, start, stop, busy, done} !== 36'd0) begin
      failures++;
      $display("FAIL reset_async: got xin=%0d pulses=%b, required all zero before next edge",
               xin, {start, stop, busy, done});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= NITER + 4; k++) begin
      @(negedge clock);
      checks++;
      if ({start, stop, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_release cycle %0d: got pulses=%b, required 0000",
                 k, {start, stop, busy, done});
      end
    end
    run_one(32'd2025, "after_reset");
  endtask

  task automatic test_niter1();
    logic [3:0] exp_v;
    logic [3:0] got_v;
    run1   = 1'b1;
    xin_in = 32'hdead_beef;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      run1   = 1'b0;
      xin_in = 32'd0;
      exp_v  = {(k == 1), (k == 3), (k <= 3), (k == 4)};
      got_v  = {start1, stop1, busy1, done1};
      checks++;
      if (got_v !== exp_v || xin1 !== 32'hdead_beef) begin
        failures++;
        $display("FAIL niter1 cycle %0d: got pulses=%b xin=%h, required %b xin=deadbeef",
                 k, got_v, xin1, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_run();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_niter1();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sqrt_control.md
Name: sqrt_control

Overview:
- Control unit directly upstream of the square-root datapath. Drives its `start`, `stop` and `xin` inputs.
- Accepts a request and 32-bit operand from the host, then sequences one `start` pulse.
- Waits a fixed number of iteration cycles, then issues one `stop` pulse so the datapath loads its `sqrt` output register.
- Finally reports completion with a one-cycle `done` pulse.

Parameters:
- NITER, 16, number of datapath iteration cycles between `start` and `stop` (must be >= 1).
- CW, 5, iteration counter width (must hold NITER-1).

Ports:
- clock  input  1  master clock, rising edge.
- reset_n  input  1  asynchronous reset, active low.
- run  input  1  request a new square root; sampled on the rising clock edge.
- abort  input  1  synchronous abort of the operation in progress.
- xin_in  input  32  operand from the host; captured when `run` is accepted.
- xin  output  32  registered operand, wired to the datapath `xin`.
- start  output  1  one-cycle pulse, wired to the datapath `start`.
- stop  output  1  one-cycle pulse, wired to the datapath `stop`.
- busy  output  1  high while an operation is in progress (START, ITER, STOP).
- done  output  1  one-cycle pulse; datapath `sqrt` is valid from this cycle onward.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, counter=0, xin=0, start=stop=busy=done=0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- States: IDLE, START, ITER, STOP, DONE.
- IDLE:
  - All pulses are low and busy=0.
  - run=1 and abort=0: xin<=xin_in, go to START.
  - Otherwise stay in IDLE.
- START:
  - start=1, busy=1.
  - counter<=NITER-1, go to ITER.
- ITER:
  - busy=1.
  - counter!=0: counter decrements and the state stays ITER.
  - counter==0: go to STOP.
  - The state lasts exactly NITER cycles.
- STOP: stop=1, busy=1, go to DONE.
- DONE:
  - done=1, busy=0.
  - run=1 and abort=0: capture xin_in and go to START (back-to-back operation with no IDLE cycle).
  - Otherwise go to IDLE.
- Latency: with run sampled at edge 0:
  - start is high in cycle 1;
  - stop is high in cycle NITER+2;
  - done is high in cycle NITER+3.
  - For NITER=16: start in cycle 1, stop in cycle 18, done in cycle 19.
- xin is stable from capture until the next accepted run. It is never modified mid-operation.
- run during START, ITER or STOP is ignored; requests are not queued.
- abort=1 in START, ITER or STOP:
  - next state is IDLE;
  - no stop and no done are issued;
  - xin keeps its value.
- abort has priority over run in every state. abort in IDLE or DONE suppresses acceptance of run.
- run held high continuously restarts the sequence every NITER+3 cycles.
- reset_n asserted mid-operation: immediate return to reset values, with no stop or done pulse. First acceptance of run is at the first rising edge after reset_n deasserts.
- Counter arithmetic is unsigned CW bits. It never wraps, because the decrement is gated by counter!=0.
- With NITER=1 the ITER state lasts one cycle: stop in cycle 3, done in cycle 4.

Test Plan:
- Reset, then run=1 for one cycle with xin_in=32'd144 -> xin=144 from cycle 1; start pulse in cycle 1; stop in cycle 18; done in cycle 19; busy high in cycles 1-18.
- run held high with xin_in=100 then 81 (changing at done) -> second start in the cycle after done; xin=81; no IDLE cycle between operations.
- run pulsed again in cycle 5 with xin_in=7 during an operation on 144 -> ignored; xin stays 144; exactly one done, in cycle 19.
- abort=1 in cycle 10 -> IDLE in cycle 11; no stop and no done observed; next run accepted normally.
- reset_n pulled low in cycle 8, asynchronously mid-cycle -> all outputs 0 before the next edge; no stop or done after release.
- NITER=1 build, run at edge 0 -> start in cycle 1, stop in cycle 3, done in cycle 4.
